// File: rtl/lc3_io_regs.sv
// LC-3 keyboard/display device registers: KBSR/KBDR/DSR/DDR with a small
// keyboard FIFO and a single-entry display output over valid/ready.
module lc3_io_regs #(
    parameter int unsigned KB_DEPTH  = 4,
    parameter logic [15:0] KBSR_ADDR = 16'hFE00,
    parameter logic [15:0] KBDR_ADDR = 16'hFE02,
    parameter logic [15:0] DSR_ADDR  = 16'hFE04,
    parameter logic [15:0] DDR_ADDR  = 16'hFE06
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] addr,
    input  logic        we,
    input  logic        re,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        io_hit,
    input  logic        kb_valid,
    input  logic [7:0]  kb_data,
    output logic        kb_ready,
    output logic        disp_valid,
    output logic [7:0]  disp_data,
    input  logic        disp_ready,
    output logic [15:0] KBSR,
    output logic [15:0] DSR
);

    localparam int unsigned PTR_W = (KB_DEPTH > 1) ? $clog2(KB_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(KB_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(KB_DEPTH);

    logic [7:0]       fifo [KB_DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [CNT_W-1:0] count;
    logic             kb_ie, d_ie;

    logic hit_kbsr, hit_kbdr, hit_dsr, hit_ddr;
    logic kb_rdy, push, pop, ddr_store;
    logic unused_wdata;

    // Address decode
    assign hit_kbsr = (addr == KBSR_ADDR);
    assign hit_kbdr = (addr == KBDR_ADDR);
    assign hit_dsr  = (addr == DSR_ADDR);
    assign hit_ddr  = (addr == DDR_ADDR);
    assign io_hit   = hit_kbsr | hit_kbdr | hit_dsr | hit_ddr;

    assign kb_rdy   = (count != '0);
    assign kb_ready = (count != CNT_FULL);
    assign push     = kb_valid & kb_ready;
    // A simultaneous store wins over the load's pop side effect
    assign pop      = re & ~we & hit_kbdr & kb_rdy;
    assign ddr_store = we & hit_ddr & ~disp_valid;

    assign KBSR = {kb_rdy, kb_ie, 14'b0};
    assign DSR  = {~disp_valid, d_ie, 14'b0};

    assign unused_wdata = ^{wdata[15], wdata[13:8]};

    // Load data mux
    always_comb begin
        rdata = 16'h0000;
        if (hit_kbsr) begin
            rdata = KBSR;
        end else if (hit_kbdr) begin
            if (kb_rdy) begin
                rdata = {8'h00, fifo[rd_ptr]};
            end
        end else if (hit_dsr) begin
            rdata = DSR;
        end else if (hit_ddr) begin
            rdata = {8'h00, disp_data};
        end
    end

    // FIFO storage needs no reset: an empty FIFO never exposes its contents
    always_ff @(posedge clk) begin
        if (push) begin
            fifo[wr_ptr] <= kb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= PTR_W'(wr_ptr + 1'b1);
            end
            if (pop) begin
                rd_ptr <= PTR_W'(rd_ptr + 1'b1);
            end
            if (push && !pop) begin
                count <= CNT_W'(count + 1'b1);
            end else if (pop && !push) begin
                count <= CNT_W'(count - 1'b1);
            end
        end
    end

    // Interrupt-enable bits and display channel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kb_ie      <= 1'b0;
            d_ie       <= 1'b0;
            disp_valid <= 1'b0;
            disp_data  <= 8'h00;
        end else begin
            if (we && hit_kbsr) begin
                kb_ie <= wdata[14];
            end
            if (we && hit_dsr) begin
                d_ie <= wdata[14];
            end
            if (ddr_store) begin
                disp_data  <= wdata[7:0];
                disp_valid <= 1'b1;
            end else if (disp_valid && disp_ready) begin
                disp_valid <= 1'b0;
            end
        end
    end

endmodule
